// File: rtl/cpu_writeback_buffer_pkg.sv
// Shared write-back types for the CPU register-file path: entry layout,
// register/data widths and the ALU result saturation helper.
package cpu_pkg;

  localparam int DATA_W              = 4;
  localparam int NUMBER_OF_REGISTERS = 8;
  localparam int WB_ADDR_W           = $clog2(NUMBER_OF_REGISTERS);

  typedef logic        [WB_ADDR_W-1:0] addr_t;
  typedef logic signed [DATA_W-1:0]    data_t;

  typedef struct packed {
    addr_t addr;
    data_t data;
  } wb_entry_t;

  // Clamp an 8-bit signed ALU result into the 4-bit signed register range.
  function automatic data_t sat8_to_4(input logic signed [7:0] value);
    if (value > 8'sd7) begin
      return 4'b0111;
    end else if (value < -8'sd8) begin
      return 4'b1000;
    end else begin
      return value[3:0];
    end
  endfunction

endpackage

// File: rtl/cpu_writeback_buffer_wb_fifo.sv
// Queue of pending register-file writes. Circular buffer with a registered
// occupancy count; pointers wrap naturally because DEPTH is a power of two.
// With WB_FORWARD_EN defined, the queued entries are also exposed in age
// order (index 0 = oldest) for the forwarding compare in the parent.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  wb_entry_t             push_entry_i,
  input  logic                  pop_i,
  output wb_entry_t             head_o,
  output logic                  full_o,
  output logic                  empty_o,
`ifdef WB_FORWARD_EN
  output wb_entry_t [DEPTH-1:0] age_entries_o,
`endif
  output logic [CNT_W-1:0]      count_o
);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Next-state pointers and occupancy.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  // Pointer and count state.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; count/pointers alone define which slots are valid.
    if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
  end

`ifdef WB_FORWARD_EN
  // Present entries oldest-first for the youngest-match search.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age_entries_o[i] = mem_q[rd_ptr_q + PTR_W'(i)];
    end
  end
`endif

endmodule

// File: rtl/cpu_writeback_buffer.sv
// Write-back buffer in front of the register-file write port. Arbitrates the
// ALU and tensor producers round-robin on contention, saturates ALU results,
// drops address-0 writes, queues the rest and drains one write per cycle.
// Optional macro WB_FORWARD_EN adds two combinational forwarding lookups.
module cpu_writeback_buffer
  import cpu_pkg::*;
#(
  parameter  int NUMBER_OF_REGISTERS = 8,
  parameter  int FIFO_DEPTH          = 4,
  localparam int ADDR_W              = $clog2(NUMBER_OF_REGISTERS),
  localparam int CNT_W               = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     clock_in,
  input  logic                     reset_in,
  input  logic                     alu_valid_in,
  output logic                     alu_ready_out,
  input  logic [ADDR_W-1:0]        alu_address_in,
  input  logic signed [7:0]        alu_data_in,
  input  logic                     tensor_valid_in,
  output logic                     tensor_ready_out,
  input  logic [ADDR_W-1:0]        tensor_address_in,
  input  logic signed [DATA_W-1:0] tensor_data_in,
  input  logic                     stall_in,
`ifdef WB_FORWARD_EN
  input  logic [ADDR_W-1:0]        fwd_address1_in,
  input  logic [ADDR_W-1:0]        fwd_address2_in,
  output logic                     fwd_hit1_out,
  output logic                     fwd_hit2_out,
  output logic signed [DATA_W-1:0] fwd_data1_out,
  output logic signed [DATA_W-1:0] fwd_data2_out,
`endif
  output logic                     write_enable_out,
  output logic [ADDR_W-1:0]        write_register_address_out,
  output logic signed [DATA_W-1:0] write_data_out,
  output logic [CNT_W-1:0]         pending_count_out
);

  // Round-robin pointer: 0 favours the ALU, 1 favours the tensor core.
  logic      rr_q, rr_d;
  logic      we_q, we_d;
  wb_entry_t out_q, out_d;
  wb_entry_t in_entry, fifo_head;
  logic      fifo_full, fifo_empty, push, pop, contested, grant_alu, grant_tensor;
`ifdef WB_FORWARD_EN
  wb_entry_t [FIFO_DEPTH-1:0] fifo_age;
`endif

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk          (clock_in),
    .rst          (reset_in),
    .push_i       (push),
    .push_entry_i (in_entry),
    .pop_i        (pop),
    .head_o       (fifo_head),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
`ifdef WB_FORWARD_EN
    .age_entries_o(fifo_age),
`endif
    .count_o      (pending_count_out)
  );

  // Arbitration, saturation and drain decisions.
  always_comb begin
    contested        = alu_valid_in && tensor_valid_in;
    alu_ready_out    = !fifo_full && !(contested && rr_q);
    tensor_ready_out = !fifo_full && !(contested && !rr_q);
    grant_alu        = alu_valid_in && alu_ready_out;
    grant_tensor     = tensor_valid_in && tensor_ready_out;
    rr_d             = (contested && !fifo_full) ? !rr_q : rr_q;

    in_entry = '{addr: alu_address_in, data: sat8_to_4(alu_data_in)};
    if (grant_tensor) in_entry = '{addr: tensor_address_in, data: tensor_data_in};
    // Address 0 is hard-wired in the register file: accept but never queue.
    push = (grant_alu || grant_tensor) && (in_entry.addr != '0);

    pop   = !stall_in && !fifo_empty;
    we_d  = we_q;
    out_d = out_q;
    if (!stall_in) begin
      we_d = !fifo_empty;
      if (!fifo_empty) out_d = fifo_head;
    end
  end

  // Output registers and arbiter pointer.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      rr_q  <= 1'b0;
      we_q  <= 1'b0;
      out_q <= '0;
    end else begin
      rr_q  <= rr_d;
      we_q  <= we_d;
      out_q <= out_d;
    end
  end

  assign write_enable_out           = we_q;
  assign write_register_address_out = out_q.addr;
  assign write_data_out             = out_q.data;

`ifdef WB_FORWARD_EN
  typedef struct packed {
    logic  hit;
    data_t data;
  } fwd_t;

  // Output register first, then FIFO oldest-to-youngest, so the youngest queued match wins.
  function automatic fwd_t fwd_lookup(input logic [ADDR_W-1:0] addr,
                                      input wb_entry_t [FIFO_DEPTH-1:0] age,
                                      input logic [CNT_W-1:0] count,
                                      input logic out_valid,
                                      input wb_entry_t out_entry);
    fwd_t r = '0;
    if (out_valid && out_entry.addr == addr) r = '{hit: 1'b1, data: out_entry.data};
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (i < int'(count) && age[i].addr == addr) r = '{hit: 1'b1, data: age[i].data};
    end
    if (addr == '0) r = '0;
    return r;
  endfunction

  // Combinational forwarding ports.
  always_comb begin
    fwd_t f1, f2;
    f1            = fwd_lookup(fwd_address1_in, fifo_age, pending_count_out, we_q, out_q);
    f2            = fwd_lookup(fwd_address2_in, fifo_age, pending_count_out, we_q, out_q);
    fwd_hit1_out  = f1.hit;
    fwd_data1_out = f1.data;
    fwd_hit2_out  = f2.hit;
    fwd_data2_out = f2.data;
  end
`endif

endmodule

// File: tb/tb_cpu_writeback_buffer.sv
// Self-checking bench for cpu_writeback_buffer. Expected writes are queued
// when a handshake is predicted and compared when the DUT issues a write.
module tb_cpu_writeback_buffer;
  import cpu_pkg::*;

  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

  logic        clock_in = 1'b0;
  logic        reset_in;
  logic        alu_valid_in, tensor_valid_in, stall_in;
  logic        alu_ready_out, tensor_ready_out;
  addr_t       alu_address_in, tensor_address_in;
  logic signed [7:0] alu_data_in;
  data_t       tensor_data_in;
  logic        write_enable_out;
  addr_t       write_register_address_out;
  data_t       write_data_out;
  logic [CNT_W-1:0] pending_count_out;
`ifdef WB_FORWARD_EN
  addr_t       fwd_address1_in, fwd_address2_in;
  logic        fwd_hit1_out, fwd_hit2_out;
  data_t       fwd_data1_out, fwd_data2_out;
`endif

  int        n_cmp = 0;
  int        n_err = 0;
  wb_entry_t sb[$];
  int        m_count = 0;
  bit        m_rr = 1'b0;
  bit        mon_en = 1'b0;

  cpu_writeback_buffer #(.NUMBER_OF_REGISTERS(8), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clock_in                  (clock_in),
    .reset_in                  (reset_in),
    .alu_valid_in              (alu_valid_in),
    .alu_ready_out             (alu_ready_out),
    .alu_address_in            (alu_address_in),
    .alu_data_in               (alu_data_in),
    .tensor_valid_in           (tensor_valid_in),
    .tensor_ready_out          (tensor_ready_out),
    .tensor_address_in         (tensor_address_in),
    .tensor_data_in            (tensor_data_in),
    .stall_in                  (stall_in),
`ifdef WB_FORWARD_EN
    .fwd_address1_in           (fwd_address1_in),
    .fwd_address2_in           (fwd_address2_in),
    .fwd_hit1_out              (fwd_hit1_out),
    .fwd_hit2_out              (fwd_hit2_out),
    .fwd_data1_out             (fwd_data1_out),
    .fwd_data2_out             (fwd_data2_out),
`endif
    .write_enable_out          (write_enable_out),
    .write_register_address_out(write_register_address_out),
    .write_data_out            (write_data_out),
    .pending_count_out         (pending_count_out)
  );

  always #5 clock_in = ~clock_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic data_t sat_model(input logic signed [7:0] v);
    if (v > 7) return 4'b0111;
    if (v < -8) return 4'b1000;
    return v[3:0];
  endfunction

  // Every edge taken without stall that shows write_enable is one fresh register-file write.
  always @(posedge clock_in) begin : monitor
    logic      st_at_edge;
    wb_entry_t exp_e;
    st_at_edge = stall_in;
    #1;
    if (mon_en && !reset_in && !st_at_edge && write_enable_out) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got addr=%0d data=%0d, want no write",
                 write_register_address_out, write_data_out);
      end else begin
        exp_e = sb.pop_front();
        if (write_register_address_out !== exp_e.addr || write_data_out !== exp_e.data) begin
          n_err++;
          $display("FAIL write_order: got addr=%0d data=%0d, want addr=%0d data=%0d",
                   write_register_address_out, write_data_out, exp_e.addr, exp_e.data);
        end
      end
    end
  end

  // One clock cycle of stimulus: drive at negedge, check ready/count, predict the handshake.
  task automatic offer(input logic av, input addr_t aa, input logic signed [7:0] ad,
                       input logic tv, input addr_t ta, input data_t td, input logic st);
    logic      exp_full, contested, exp_ar, exp_tr, push, pop;
    wb_entry_t e;
    @(negedge clock_in);
    alu_valid_in = av; alu_address_in = aa; alu_data_in = ad;
    tensor_valid_in = tv; tensor_address_in = ta; tensor_data_in = td;
    stall_in = st;
    #1;
    exp_full  = (m_count == FIFO_DEPTH);
    contested = av && tv;
    exp_ar    = !exp_full && !(contested && m_rr);
    exp_tr    = !exp_full && !(contested && !m_rr);
    n_cmp++;
    if (alu_ready_out !== exp_ar || tensor_ready_out !== exp_tr) begin
      n_err++;
      $display("FAIL ready: got alu=%b tensor=%b, want alu=%b tensor=%b",
               alu_ready_out, tensor_ready_out, exp_ar, exp_tr);
    end
    n_cmp++;
    if (pending_count_out !== CNT_W'(m_count)) begin
      n_err++;
      $display("FAIL pending_count: got %0d, want %0d", pending_count_out, m_count);
    end
    push = 1'b0;
    e    = '0;
    if (av && exp_ar) begin
      e = '{addr: aa, data: sat_model(ad)};
      push = (aa != 0);
    end else if (tv && exp_tr) begin
      e = '{addr: ta, data: td};
      push = (ta != 0);
    end
    if (contested && !exp_full) m_rr = !m_rr;
    if (push) sb.push_back(e);
    pop = !st && (m_count > 0);
    @(posedge clock_in);
    m_count = m_count + int'(push) - int'(pop);
  endtask

  task automatic idle(input logic st);
    offer(1'b0, 3'd0, 8'sd0, 1'b0, 3'd0, 4'sd0, st);
  endtask

  task automatic check_we(input string name, input logic want);
    n_cmp++;
    if (write_enable_out !== want) begin
      n_err++;
      $display("FAIL %s: got write_enable=%b, want %b", name, write_enable_out, want);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && m_count > 0; i++) idle(1'b0);
    idle(1'b0);
    idle(1'b0);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d writes still outstanding, want 0", sb.size());
    end
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    alu_valid_in = 1'b0; tensor_valid_in = 1'b0; stall_in = 1'b0;
    alu_address_in = '0; alu_data_in = '0; tensor_address_in = '0; tensor_data_in = '0;
`ifdef WB_FORWARD_EN
    fwd_address1_in = '0; fwd_address2_in = '0;
`endif
    repeat (2) @(negedge clock_in);
    n_cmp++;
    if (write_enable_out !== 1'b0 || write_register_address_out !== '0 ||
        write_data_out !== '0 || pending_count_out !== '0) begin
      n_err++;
      $display("FAIL reset_state: got we=%b addr=%0d data=%0d count=%0d, want all 0",
               write_enable_out, write_register_address_out, write_data_out, pending_count_out);
    end
    reset_in = 1'b0;
    m_count = 0; m_rr = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_saturation();
    logic signed [7:0] vals [6] = '{8'sd7, -8'sd8, 8'sd8, -8'sd9, 8'sd5, -8'sd3};
    offer(1'b1, 3'd3, 8'sd100, 1'b0, 3'd0, 4'sd0, 1'b0);
    #1;
    check_we("latency_edge_n", 1'b0);
    idle(1'b0);
    #1;
    check_we("latency_edge_n1", 1'b1);
    n_cmp++;
    if (write_register_address_out !== 3'd3 || write_data_out !== 4'sd7) begin
      n_err++;
      $display("FAIL sat_pos: got addr=%0d data=%0d, want addr=3 data=7",
               write_register_address_out, write_data_out);
    end
    offer(1'b1, 3'd3, -8'sd100, 1'b0, 3'd0, 4'sd0, 1'b0);
    idle(1'b0);
    #1;
    n_cmp++;
    if (write_data_out !== -4'sd8) begin
      n_err++;
      $display("FAIL sat_neg: got data=%0d, want -8", write_data_out);
    end
    foreach (vals[i]) offer(1'b1, addr_t'(i + 1), vals[i], 1'b0, 3'd0, 4'sd0, 1'b0);
    drain();
  endtask

  task automatic test_arbitration();
    offer(1'b1, 3'd1, 8'sd2, 1'b1, 3'd2, -4'sd3, 1'b0);
    offer(1'b0, 3'd0, 8'sd0, 1'b1, 3'd2, -4'sd3, 1'b0);
    offer(1'b1, 3'd1, 8'sd2, 1'b1, 3'd2, -4'sd3, 1'b0);
    offer(1'b1, 3'd1, 8'sd2, 1'b0, 3'd0, 4'sd0, 1'b0);
    drain();
  endtask

  task automatic test_stall_full();
    for (int i = 0; i < 4; i++) offer(1'b1, addr_t'(i + 1), 8'(i + 1), 1'b0, 3'd0, 4'sd0, 1'b1);
    offer(1'b1, 3'd5, 8'sd1, 1'b1, 3'd6, 4'sd1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      #1;
      check_we("stall_release_we", 1'b1);
    end
    n_cmp++;
    if (pending_count_out !== '0) begin
      n_err++;
      $display("FAIL stall_release_count: got %0d, want 0", pending_count_out);
    end
    drain();
  endtask

  task automatic test_addr_zero();
    offer(1'b0, 3'd0, 8'sd0, 1'b1, 3'd0, 4'sd5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      #1;
      check_we("addr_zero_we", 1'b0);
    end
  endtask

  task automatic test_mid_reset();
    offer(1'b1, 3'd1, 8'sd1, 1'b0, 3'd0, 4'sd0, 1'b0);
    offer(1'b1, 3'd2, 8'sd2, 1'b0, 3'd0, 4'sd0, 1'b0);
    offer(1'b1, 3'd3, 8'sd3, 1'b0, 3'd0, 4'sd0, 1'b1);
    offer(1'b1, 3'd4, 8'sd4, 1'b0, 3'd0, 4'sd0, 1'b1);
    @(negedge clock_in);
    alu_valid_in = 1'b0; tensor_valid_in = 1'b0; stall_in = 1'b0;
    n_cmp++;
    if (pending_count_out !== CNT_W'(3) || write_enable_out !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset: got count=%0d we=%b, want count=3 we=1",
               pending_count_out, write_enable_out);
    end
    #2 reset_in = 1'b1;
    #1;
    n_cmp++;
    if (write_enable_out !== 1'b0 || write_register_address_out !== '0 ||
        write_data_out !== '0 || pending_count_out !== '0) begin
      n_err++;
      $display("FAIL mid_reset: got we=%b addr=%0d data=%0d count=%0d, want all 0",
               write_enable_out, write_register_address_out, write_data_out, pending_count_out);
    end
    #1 reset_in = 1'b0;
    sb.delete();
    m_count = 0; m_rr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      #1;
      check_we("post_reset_we", 1'b0);
    end
  endtask

`ifdef WB_FORWARD_EN
  task automatic check_fwd(input string name, input logic h1, input data_t d1, input logic h2);
    @(negedge clock_in);
    #1;
    n_cmp++;
    if (fwd_hit1_out !== h1 || (h1 && fwd_data1_out !== d1) || fwd_hit2_out !== h2) begin
      n_err++;
      $display("FAIL %s: got hit1=%b data1=%0d hit2=%b, want hit1=%b data1=%0d hit2=%b",
               name, fwd_hit1_out, fwd_data1_out, fwd_hit2_out, h1, d1, h2);
    end
  endtask

  task automatic test_forward();
    offer(1'b0, 3'd0, 8'sd0, 1'b1, 3'd4, 4'sd1, 1'b1);
    offer(1'b1, 3'd4, -8'sd2, 1'b0, 3'd0, 4'sd0, 1'b1);
    alu_valid_in = 1'b0;
    fwd_address1_in = 3'd4; fwd_address2_in = 3'd5;
    check_fwd("fwd_fifo_youngest", 1'b1, -4'sd2, 1'b0);
    idle(1'b0);
    check_fwd("fwd_fifo_over_out", 1'b1, -4'sd2, 1'b0);
    idle(1'b0);
    check_fwd("fwd_out_reg", 1'b1, -4'sd2, 1'b0);
    fwd_address1_in = 3'd0;
    check_fwd("fwd_addr_zero", 1'b0, 4'sd0, 1'b0);
    drain();
  endtask
`endif

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      offer(1'($urandom_range(0, 1)), addr_t'($urandom_range(0, 7)), 8'($urandom),
            1'($urandom_range(0, 1)), addr_t'($urandom_range(0, 7)), 4'($urandom),
            1'($urandom_range(0, 3) == 0));
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_saturation();
    test_arbitration();
    test_stall_full();
    test_addr_zero();
    test_mid_reset();
`ifdef WB_FORWARD_EN
    test_forward();
`endif
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
